smart_room_multi: RTL and testbench



---
 rtl/smart_room_multi.sv | 140 ++++++++++++++
 tb/tb_smart_room_multi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/smart_room_multi.sv
// Occupancy and energy controller for a room with several doors: edge-detected
// entry/exit sensors feed a clamped people count, which drives LEDs, flags and an energy accumulator.
module smart_room_multi #(
  parameter int NUM_DOORS   = 2,
  parameter int CNT_W       = 5,
  parameter int MAX_PEOPLE  = 15,
  parameter int FULL_THRESH = 11,
  parameter int FAN_THRESH  = 4,
  parameter int ENERGY_W    = 8,
  parameter int DIV_W       = 6,
  parameter int LED_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DOORS-1:0] enter,
  input  logic [NUM_DOORS-1:0] exit_s,
  input  logic                 energy_clr,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     people_count,
  output logic [ENERGY_W-1:0]  energy,
  output logic [LED_W-1:0]     green_leds,
  output logic [LED_W-1:0]     red_leds,
  output logic                 room_full,
  output logic                 room_empty,
  output logic                 overflow_err,
  output logic                 underflow_err,
  output logic                 energy_sat
);

  localparam int SW = CNT_W + 2;
  localparam int EW = ((ENERGY_W > CNT_W) ? ENERGY_W : CNT_W) + 1;
  localparam int HW = ((LED_W > CNT_W) ? LED_W : CNT_W) + 1;

  localparam logic signed [SW-1:0] MAX_S    = SW'(MAX_PEOPLE);
  localparam logic [CNT_W-1:0]     MAX_C    = CNT_W'(MAX_PEOPLE);
  localparam logic [CNT_W-1:0]     FULL_C   = CNT_W'(FULL_THRESH);
  localparam logic [CNT_W-1:0]     FAN_C    = CNT_W'(FAN_THRESH);
  localparam logic [EW-1:0]        E_MAX    = EW'({ENERGY_W{1'b1}});
  localparam logic [HW-1:0]        LED_MAX  = HW'({LED_W{1'b1}});

  logic [NUM_DOORS-1:0] enter_q, exit_q;
  logic [NUM_DOORS-1:0] in_ev, out_ev;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ENERGY_W-1:0]  energy_q, energy_d;
  logic [DIV_W-1:0]     div_q;
  logic                 ovf_q, ovf_d, unf_q, unf_d, sat_q, sat_d;
  logic [SW-1:0]        ins, outs;
  logic signed [SW-1:0] sum;
  logic [EW-1:0]        e_sum;
  logic [HW-1:0]        half_ext;
  logic                 tick;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOORS; gi++) begin : g_edge
      assign in_ev[gi]  = enter[gi]  & ~enter_q[gi];
      assign out_ev[gi] = exit_s[gi] & ~exit_q[gi];
    end
  endgenerate

  always_comb begin
    ins  = '0;
    outs = '0;
    for (int i = 0; i < NUM_DOORS; i++) begin
      ins  = ins  + SW'(in_ev[i]);
      outs = outs + SW'(out_ev[i]);
    end
  end

  // Signed headroom of two bits lets the clamp see both overshoot and undershoot.
  always_comb begin
    sum     = signed'({2'b00, count_q}) + signed'(ins) - signed'(outs);
    count_d = sum[CNT_W-1:0];
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;
    if (sum[SW-1]) begin
      count_d = '0;
      unf_d   = 1'b1;
    end else if (sum > MAX_S) begin
      count_d = MAX_C;
      ovf_d   = 1'b1;
    end
  end

  assign tick  = &div_q;
  assign e_sum = EW'(energy_q) + EW'(count_q);

  always_comb begin
    energy_d = energy_q;
    sat_d    = sat_q;
    if (energy_clr) begin
      energy_d = '0;
      sat_d    = 1'b0;
    end else if (tick) begin
      if (e_sum > E_MAX) begin
        energy_d = {ENERGY_W{1'b1}};
        sat_d    = 1'b1;
      end else begin
        energy_d = e_sum[ENERGY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    // Sensor history tracks inputs even in reset so a held sensor is not an event.
    enter_q <= enter;
    exit_q  <= exit_s;
    if (reset) begin
      count_q  <= '0;
      energy_q <= '0;
      div_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      energy_q <= energy_d;
      div_q    <= div_q + 1'b1;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      sat_q    <= sat_d;
    end
  end

  always_comb begin
    half_ext = HW'(count_q >> 1);
    if (half_ext > LED_MAX) green_leds = '1;
    else                    green_leds = half_ext[LED_W-1:0];
    red_leds = (count_q >= FAN_C) ? green_leds : '0;
  end

  assign people_count  = count_q;
  assign energy        = energy_q;
  assign room_full     = (count_q >= FULL_C);
  assign room_empty    = (count_q == '0);
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign energy_sat    = sat_q;

endmodule

// File: tb/tb_smart_room_multi.sv
// Bench for smart_room_multi: constant vector table, hand sequences for clamps and energy,
// and randomized traffic checked every cycle against an integer occupancy/energy model.
module tb_smart_room_multi;

  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [ND-1:0] enter, exit_s;
  logic          energy_clr, err_clr;
  logic [4:0]    people_count;
  logic [7:0]    energy;
  logic [3:0]    green_leds, red_leds;
  logic          room_full, room_empty, overflow_err, underflow_err, energy_sat;

  always #5 clk = ~clk;

  smart_room_multi dut (
    .clk(clk), .reset(reset), .enter(enter), .exit_s(exit_s),
    .energy_clr(energy_clr), .err_clr(err_clr),
    .people_count(people_count), .energy(energy),
    .green_leds(green_leds), .red_leds(red_leds),
    .room_full(room_full), .room_empty(room_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .energy_sat(energy_sat)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  // Reference model state: plain integers
  int m_cnt, m_en, m_div, m_ovf, m_unf, m_sat;
  logic [ND-1:0] m_pe, m_px;

  typedef struct {
    logic [ND-1:0] en;
    logic [ND-1:0] ex;
    logic          ec;
    int            cnt;
    int            ovf;
    int            unf;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ins, outs, s, e;
    if (reset) begin
      m_cnt = 0; m_en = 0; m_div = 0; m_ovf = 0; m_unf = 0; m_sat = 0;
    end else begin
      ins = 0; outs = 0;
      for (int d = 0; d < ND; d++) begin
        if (enter[d] && !m_pe[d])  ins++;
        if (exit_s[d] && !m_px[d]) outs++;
      end
      s = m_cnt + ins - outs;
      if (err_clr) begin m_ovf = 0; m_unf = 0; end
      if (s > 15) begin s = 15; m_ovf = 1; end
      else if (s < 0) begin s = 0; m_unf = 1; end
      if (energy_clr) begin
        m_en = 0; m_sat = 0;
      end else if (m_div == 63) begin
        e = m_en + m_cnt;
        if (e > 255) begin e = 255; m_sat = 1; end
        m_en = e;
      end
      m_div = (m_div + 1) % 64;
      m_cnt = s;
    end
    m_pe = enter;
    m_px = exit_s;
  endtask

  task automatic check_all();
    int half;
    half = m_cnt / 2;
    if (half > 15) half = 15;
    chk("count", int'(people_count), m_cnt);
    chk("energy", int'(energy), m_en);
    chk("green", int'(green_leds), half);
    chk("red", int'(red_leds), (m_cnt >= 4) ? half : 0);
    chk("full", int'(room_full), (m_cnt >= 11) ? 1 : 0);
    chk("empty", int'(room_empty), (m_cnt == 0) ? 1 : 0);
    chk("ovf", int'(overflow_err), m_ovf);
    chk("unf", int'(underflow_err), m_unf);
    chk("sat", int'(energy_sat), m_sat);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    edges++;
  endtask

  task automatic pulse(logic [ND-1:0] en, logic [ND-1:0] ex);
    enter = en; exit_s = ex;
    cyc();
    enter = '0; exit_s = '0;
    cyc();
  endtask

  task automatic do_reset(logic [ND-1:0] hold);
    reset = 1'b1; enter = hold; exit_s = '0; energy_clr = 1'b0; err_clr = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    edges = 0;
  endtask

  initial begin
    tbl[0]  = '{2'b11, 2'b00, 1'b0, 2, 0, 0};
    tbl[1]  = '{2'b00, 2'b00, 1'b0, 2, 0, 0};
    tbl[2]  = '{2'b01, 2'b00, 1'b0, 3, 0, 0};
    tbl[3]  = '{2'b00, 2'b00, 1'b0, 3, 0, 0};
    tbl[4]  = '{2'b00, 2'b11, 1'b0, 1, 0, 0};
    tbl[5]  = '{2'b00, 2'b00, 1'b0, 1, 0, 0};
    tbl[6]  = '{2'b01, 2'b11, 1'b0, 0, 0, 0};
    tbl[7]  = '{2'b00, 2'b00, 1'b0, 0, 0, 0};
    tbl[8]  = '{2'b01, 2'b11, 1'b0, 0, 0, 1};
    tbl[9]  = '{2'b00, 2'b00, 1'b1, 0, 0, 0};
    tbl[10] = '{2'b10, 2'b10, 1'b0, 0, 0, 0};
    tbl[11] = '{2'b00, 2'b00, 1'b0, 0, 0, 0};

    reset = 1'b1; enter = '0; exit_s = '0; energy_clr = 1'b0; err_clr = 1'b0;
    m_pe = '0; m_px = '0;

    // Sensor held high through reset must not count
    do_reset(2'b01);
    cyc();
    cyc();
    chk("hold_count", int'(people_count), 0);
    chk("hold_empty", int'(room_empty), 1);
    enter = '0;
    cyc();

    // Vector table
    for (int i = 0; i < 12; i++) begin
      enter = tbl[i].en; exit_s = tbl[i].ex; err_clr = tbl[i].ec;
      cyc();
      $display("vec %0d: enter=%b exit=%b err_clr=%b -> count=%0d ovf=%0d unf=%0d",
               i, tbl[i].en, tbl[i].ex, tbl[i].ec, people_count, overflow_err, underflow_err);
      chk("vec_count", int'(people_count), tbl[i].cnt);
      chk("vec_ovf", int'(overflow_err), tbl[i].ovf);
      chk("vec_unf", int'(underflow_err), tbl[i].unf);
    end
    err_clr = 1'b0; enter = '0; exit_s = '0;

    // Twelve entries in pairs, then overflow clamp and error clear
    do_reset('0);
    for (int k = 1; k <= 6; k++) begin
      pulse(2'b11, 2'b00);
      chk("pair_count", int'(people_count), 2 * k);
      chk("pair_full", int'(room_full), (2 * k >= 11) ? 1 : 0);
    end
    chk("green12", int'(green_leds), 6);
    chk("red12", int'(red_leds), 6);
    pulse(2'b01, 2'b00);
    pulse(2'b01, 2'b00);
    chk("count14", int'(people_count), 14);
    pulse(2'b11, 2'b00);
    chk("count15", int'(people_count), 15);
    chk("ovf_set", int'(overflow_err), 1);
    enter = 2'b01; err_clr = 1'b1;
    cyc();
    chk("ovf_setwins", int'(overflow_err), 1);
    enter = '0;
    cyc();
    err_clr = 1'b0;
    chk("ovf_clr", int'(overflow_err), 0);
    chk("count_hold15", int'(people_count), 15);
    $display("seq overflow: count=%0d ovf=%0d", people_count, overflow_err);

    // Energy accumulation with three occupants
    do_reset('0);
    pulse(2'b11, 2'b00);
    pulse(2'b01, 2'b00);
    while (edges < 64) cyc();
    chk("energy64", int'(energy), 3);
    while (edges < 128) cyc();
    chk("energy128", int'(energy), 6);
    $display("seq energy: count=%0d energy=%0d", people_count, energy);

    // Saturation at full occupancy, then clear on a tick cycle
    do_reset('0);
    for (int k = 0; k < 7; k++) pulse(2'b11, 2'b00);
    pulse(2'b01, 2'b00);
    chk("sat_count", int'(people_count), 15);
    while (edges < 1088) cyc();
    chk("e_exact255", int'(energy), 255);
    chk("sat_not_yet", int'(energy_sat), 0);
    while (edges < 1152) cyc();
    chk("e_sat255", int'(energy), 255);
    chk("sat_set", int'(energy_sat), 1);
    while (edges < 1215) cyc();
    energy_clr = 1'b1;
    cyc();
    energy_clr = 1'b0;
    chk("clr_energy", int'(energy), 0);
    chk("clr_sat", int'(energy_sat), 0);
    while (edges < 1280) cyc();
    chk("after_clr_tick", int'(energy), 15);
    $display("seq saturate: energy=%0d sat=%0d", energy, energy_sat);

    // Randomized traffic against the model
    do_reset('0);
    for (int i = 0; i < 3000; i++) begin
      if (((i / 250) % 2) == 0) begin
        enter  = ND'($urandom_range(0, 3));
        exit_s = ND'($urandom_range(0, 3) & $urandom_range(0, 3));
      end else begin
        enter  = ND'($urandom_range(0, 3) & $urandom_range(0, 3));
        exit_s = ND'($urandom_range(0, 3));
      end
      reset      = ($urandom_range(0, 399) == 0);
      err_clr    = ($urandom_range(0, 39) == 0);
      energy_clr = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0; err_clr = 1'b0; energy_clr = 1'b0; enter = '0; exit_s = '0;
    $display("random: 3000 cycles, final count=%0d energy=%0d", people_count, energy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
